md_unit: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the single-cycle `alu` in the execute stage. It accepts operands and an M-extension op via a valid/ready handshake and iterates for a fixed number of cycles. It returns a 32-bit result with a one-cycle valid pulse. Hazard logic stalls on `ready_o` low and writes back on `valid_o`.

---
 rtl/md_unit_pkg.sv | 35 +++
 rtl/md_unit_if.sv | 23 ++
 rtl/md_unit_sign_fix.sv | 31 +++
 rtl/md_unit.sv | 151 +++++++++++++++
 tb/tb_md_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package md_unit_pkg;

    localparam int unsigned MD_ITERS = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } md_state_t;

    // True when both operands are interpreted as two's complement.
    function automatic logic is_signed_op(md_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic is_div_op(md_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bus between the execute stage and md_unit.
interface md_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic [WIDTH-1:0] result_o;
    logic             valid_o;

    modport master (
        output valid_i, op_i, a_i, b_i, flush_i,
        input  ready_o, result_o, valid_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, flush_i,
        output ready_o, result_o, valid_o
    );
endinterface

// File: rtl/md_unit_sign_fix.sv
// Operand sign stripping (PREP) and result negation (FIX) for md_unit.
module md_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               a_signed_i,
    input  logic               b_signed_i,
    output logic [WIDTH-1:0]   a_abs_o,
    output logic [WIDTH-1:0]   b_abs_o,
    output logic               a_neg_o,
    output logic               b_neg_o,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic               prod_neg_i,
    output logic [2*WIDTH-1:0] prod_o,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic               rem_neg_i,
    output logic [WIDTH-1:0]   rem_o
);

    // Magnitudes of the operands plus their sign flags; negation of wide product/quotient and remainder.
    always_comb begin
        a_neg_o = a_signed_i & a_i[WIDTH-1];
        b_neg_o = b_signed_i & b_i[WIDTH-1];
        a_abs_o = a_neg_o ? (~a_i + 1'b1) : a_i;
        b_abs_o = b_neg_o ? (~b_i + 1'b1) : b_i;
        prod_o  = prod_neg_i ? (~prod_i + 1'b1) : prod_i;
        rem_o   = rem_neg_i ? (~rem_i + 1'b1) : rem_i;
    end

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: fixed 35-cycle latency, one op per 36 cycles.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       reset_i,
    md_unit_if.slave   bus
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    md_op_t             op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   babs_q, babs_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               nega_q, nega_d, negb_q, negb_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]   a_abs, b_abs, rem_fixed;
    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a_i        (a_q),
        .b_i        (b_q),
        .a_signed_i (is_signed_op(op_q) || (op_q == OP_MULHSU)),
        .b_signed_i (is_signed_op(op_q)),
        .a_abs_o    (a_abs),
        .b_abs_o    (b_abs),
        .a_neg_o    (a_neg),
        .b_neg_o    (b_neg),
        .prod_i     (fix_in),
        .prod_neg_i (nega_q ^ negb_q),
        .prod_o     (fix_out),
        .rem_i      (acc_q[2*WIDTH-1:WIDTH]),
        .rem_neg_i  (nega_q),
        .rem_o      (rem_fixed)
    );

    // One iteration step: acc holds {hi, lo}; multiply uses hi as partial sum, divide uses hi as remainder and lo as quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, babs_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, babs_q};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        fix_in = is_div_op(op_q) ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        babs_d   = babs_q;
        acc_d    = acc_q;
        nega_d   = nega_q;
        negb_d   = negb_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid_i && !bus.flush_i) begin
                    state_d = ST_PREP;
                    op_d    = md_op_t'(bus.op_i);
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                end
            end
            ST_PREP: begin
                acc_d   = {{WIDTH{1'b0}}, a_abs};
                babs_d  = b_abs;
                nega_d  = a_neg;
                negb_d  = b_neg;
                cnt_d   = '0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                acc_d = is_div_op(op_q) ? div_next : mul_next;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIX: begin
                // Divide-by-zero is overridden here; signed overflow falls out of the magnitude datapath.
                case (op_q)
                    OP_MUL:                       result_d = fix_out[WIDTH-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = fix_out[2*WIDTH-1:WIDTH];
                    OP_DIV, OP_DIVU:              result_d = (b_q == '0) ? '1 : fix_out[WIDTH-1:0];
                    default:                      result_d = (b_q == '0) ? a_q : rem_fixed;
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.flush_i && (state_q != ST_DONE)) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            babs_q   <= '0;
            acc_q    <= '0;
            nega_q   <= 1'b0;
            negb_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            babs_q   <= babs_d;
            acc_q    <= acc_d;
            nega_q   <= nega_d;
            negb_q   <= negb_d;
            result_q <= result_d;
        end
    end

    assign bus.ready_o  = (state_q == ST_IDLE);
    assign bus.valid_o  = (state_q == ST_DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: reference model built from RV32M arithmetic rules.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    md_unit_if #(.WIDTH(W)) bus ();

    md_unit #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint      sa  = longint'(int'(a));
        longint      sbv = longint'(int'(b));
        longint      ub  = longint'({32'b0, b});
        logic [63:0] p;
        logic [31:0] r;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = sa * sbv; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = int'(a) / int'(b);
            end
            3'd5: begin
                if (b == 0) r = '1;
                else r = a / b;
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else r = int'(a) % int'(b);
            end
            default: begin
                if (b == 0) r = a;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    function automatic string op_name(logic [2:0] op);
        md_op_t o = md_op_t'(op);
        return o.name();
    endfunction

    // Monitor: every valid_o pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.valid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got result %h with no request pending at cycle %0d", bus.result_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, bus.result_o, e.res);
                check({e.name, "_latency"}, 32'(cyc + 1 - e.acc), 32'd35);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_o) check("ready_timeout", 32'(bus.ready_o), 32'd1);
    endtask

    task automatic scramble();
        bus.op_i = 3'($urandom);
        bus.a_i  = $urandom;
        bus.b_i  = $urandom;
    endtask

    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b, bit expect_res, output int acc);
        exp_t e;
        wait_ready();
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(negedge clk);
        acc = cyc;
        bus.valid_i = 1'b0;
        scramble();
        if (expect_res) begin
            e.res  = ref_md(op, a, b);
            e.acc  = acc;
            e.name = op_name(op);
            sb.push_back(e);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] pool [5];
        pool[0] = 32'h0;
        pool[1] = 32'h1;
        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000;
        pool[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return pool[$urandom_range(4)];
        return $urandom;
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        dir [12];
        int          acc;
        int          n1;
        exp_t        e;
        logic        busy_ready;
        int          n;

        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i    = '0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (3) @(negedge clk);
        check("reset_ready",  32'(bus.ready_o), 32'd1);
        check("reset_valid",  32'(bus.valid_o), 32'd0);
        check("reset_result", bus.result_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        dir[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD};
        dir[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        dir[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000};
        dir[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        dir[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2};
        dir[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2};
        dir[6]  = '{3'd5, 32'd100,       32'd7};
        dir[7]  = '{3'd7, 32'd100,       32'd7};
        dir[8]  = '{3'd5, 32'd5,         32'd0};
        dir[9]  = '{3'd7, 32'd5,         32'd0};
        dir[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF};
        dir[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF};
        foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, 1'b1, acc);

        // Back-to-back: second request held high while busy, accepted when ready returns.
        wait_ready();
        bus.valid_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.a_i     = 32'h1234_5678;
        bus.b_i     = 32'h9ABC_DEF0;
        @(negedge clk);
        n1 = cyc;
        e.res = ref_md(3'd0, 32'h1234_5678, 32'h9ABC_DEF0); e.acc = n1; e.name = "B2B1";
        sb.push_back(e);
        bus.op_i = 3'd5;
        bus.a_i  = 32'hDEAD_BEEF;
        bus.b_i  = 32'd1000;
        busy_ready = 1'b0;
        while (cyc < n1 + 36) begin
            if (cyc <= n1 + 34 && bus.ready_o) busy_ready = 1'b1;
            if (cyc == n1 + 35) check("b2b_ready_return", 32'(bus.ready_o), 32'd1);
            @(negedge clk);
        end
        check("b2b_busy_ready_low", 32'(busy_ready), 32'd0);
        check("b2b_second_accepted", 32'(bus.ready_o), 32'd0);
        e.res = ref_md(3'd5, 32'hDEAD_BEEF, 32'd1000); e.acc = n1 + 36; e.name = "B2B2";
        sb.push_back(e);
        bus.valid_i = 1'b0;
        scramble();

        // Flush 10 cycles after accept: no result, idle next cycle.
        issue(3'd4, 32'd12345, 32'd17, 1'b0, acc);
        while (cyc < acc + 9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_ready", 32'(bus.ready_o), 32'd1);
        check("flush_valid", 32'(bus.valid_o), 32'd0);
        issue(3'd0, 32'd3, 32'd4, 1'b1, acc);
        wait_ready();
        @(negedge clk);

        // Reset in the middle of CALC.
        issue(3'd1, 32'hCAFE_F00D, 32'h0BAD_1DEA, 1'b0, acc);
        while (cyc < acc + 15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready",  32'(bus.ready_o), 32'd1);
        check("rst_mid_valid",  32'(bus.valid_o), 32'd0);
        check("rst_mid_result", bus.result_o, 32'd0);

        // Flush together with valid in IDLE blocks acceptance.
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.a_i     = 32'd9;
        bus.b_i     = 32'd9;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        check("flush_valid_idle_ready", 32'(bus.ready_o), 32'd1);
        @(negedge clk);
        check("flush_valid_idle_ready2", 32'(bus.ready_o), 32'd1);

        // Randomized traffic.
        repeat (40) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            issue(op, a, b, 1'b1, acc);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
